// File: rtl/prox_pkg.sv
// prox_pkg: shared zone encoding and chime timing for proximity_monitor.
// The chime constants are only consumed when PROX_CHIME_EN is defined.
package prox_pkg;

  // Confirmed / raw warning zone, ordered by urgency so a plain compare finds the worst.
  typedef logic [2:0] zone_t;

  localparam zone_t ZONE_OFF     = 3'd0;
  localparam zone_t ZONE_FAR     = 3'd1;
  localparam zone_t ZONE_MID     = 3'd2;
  localparam zone_t ZONE_NEAR    = 3'd3;
  localparam zone_t ZONE_CRIT    = 3'd4;
  localparam zone_t ZONE_CONTACT = 3'd5;

  // Chime period in ticks; the chime is high for the first half of each period.
  localparam int          CHIME_CNT_W   = 5;
  localparam logic [4:0]  CHIME_PER_FAR  = 5'd16;
  localparam logic [4:0]  CHIME_PER_MID  = 5'd8;
  localparam logic [4:0]  CHIME_PER_NEAR = 5'd4;

  // Period for a zone. OFF/CRIT/CONTACT do not blink; they get the longest period so
  // the free-running phase counter stays well-defined.
  function automatic logic [4:0] chime_period(input zone_t z);
    case (z)
      ZONE_MID:  return CHIME_PER_MID;
      ZONE_NEAR: return CHIME_PER_NEAR;
      default:   return CHIME_PER_FAR;
    endcase
  endfunction

endpackage

// File: rtl/prox_channel.sv
// prox_channel: one sensor channel. Classifies each valid sample into a zone,
// debounces zone changes over CONFIRM agreeing samples, and latches contact
// events until cleared.
module prox_channel
  import prox_pkg::*;
#(
  parameter int DIST_W  = 5,
  parameter int CONFIRM = 2,
  parameter int Z1_FT   = 20,
  parameter int Z2_FT   = 10,
  parameter int Z3_FT   = 5,
  parameter int Z4_FT   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic              present,
  input  logic [DIST_W-1:0] distance,
  output zone_t             zone,
  output logic [DIST_W-1:0] dist_q,
  output logic              contact
);

  localparam int STREAK_W = $clog2(CONFIRM + 1);
  localparam logic [STREAK_W-1:0] CONFIRM_S = STREAK_W'(CONFIRM);
  localparam logic [STREAK_W-1:0] STREAK_1  = STREAK_W'(1);

  localparam logic [DIST_W-1:0] Z1_D = DIST_W'(Z1_FT);
  localparam logic [DIST_W-1:0] Z2_D = DIST_W'(Z2_FT);
  localparam logic [DIST_W-1:0] Z3_D = DIST_W'(Z3_FT);
  localparam logic [DIST_W-1:0] Z4_D = DIST_W'(Z4_FT);

  localparam logic [0:0] ST_TRACK   = 1'b0;
  localparam logic [0:0] ST_LATCHED = 1'b1;

  logic [0:0]          state;
  zone_t               cand;
  logic [STREAK_W-1:0] streak;

  zone_t               raw;
  zone_t               cand_nx;
  logic [STREAK_W-1:0] streak_nx;
  logic                confirm_hit;
  logic                contact_smp;

  function automatic zone_t classify(input logic pres, input logic [DIST_W-1:0] d);
    if (!pres || d > Z1_D) return ZONE_OFF;
    if (d == '0)           return ZONE_CONTACT;
    if (d <= Z4_D)         return ZONE_CRIT;
    if (d <= Z3_D)         return ZONE_NEAR;
    if (d <= Z2_D)         return ZONE_MID;
    return ZONE_FAR;
  endfunction

  assign raw         = classify(present, distance);
  assign contact_smp = sample_valid && (raw == ZONE_CONTACT);
  assign contact     = (state == ST_LATCHED);

  // Candidate/streak update for the current sample and whether it confirms a new zone.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    cand_nx   = raw;
    streak_nx = STREAK_1;
    if (raw == cand) begin
      cand_nx   = cand;
      streak_nx = (streak >= CONFIRM_S) ? streak : streak + STREAK_1;
    end
    confirm_hit = (streak_nx >= CONFIRM_S) && (cand_nx != zone);
  end

  // TRACK/LATCHED state machine with debounced zone and last confirmed distance.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (RST) begin
      state  <= ST_TRACK;
      zone   <= ZONE_OFF;
      dist_q <= '0;
      cand   <= ZONE_OFF;
      streak <= '0;
    end else if (state == ST_LATCHED) begin
      // A contact sample arriving with clear re-asserts the latch, so it wins.
      if (clear && !contact_smp) begin
        state  <= ST_TRACK;
        zone   <= ZONE_OFF;
        cand   <= ZONE_OFF;
        streak <= '0;
      end
    end else if (!enable) begin
      zone   <= ZONE_OFF;
      cand   <= ZONE_OFF;
      streak <= '0;
    end else if (sample_valid) begin
      if (contact_smp) begin
        state  <= ST_LATCHED;
        zone   <= ZONE_CONTACT;
        dist_q <= distance;
        cand   <= ZONE_OFF;
        streak <= '0;
      end else begin
        cand   <= cand_nx;
        streak <= streak_nx;
        if (confirm_hit) begin
          zone   <= cand_nx;
          dist_q <= distance;
        end
      end
    end
  end

endmodule

// File: rtl/proximity_monitor.sv
// proximity_monitor: N_CH debounced distance channels, registered most-urgent
// channel reduction, and an optional parking chime.
// Build option: define PROX_CHIME_EN to compile in the chime generator;
// without it chime is tied low and no chime registers exist.
module proximity_monitor
  import prox_pkg::*;
#(
  parameter  int N_CH         = 2,
  parameter  int DIST_W       = 5,
  parameter  int CONFIRM      = 2,
  parameter  int Z1_FT        = 20,
  parameter  int Z2_FT        = 10,
  parameter  int Z3_FT        = 5,
  parameter  int Z4_FT        = 1,
  parameter  int CLK_PER_TICK = 1000,
  localparam int NCH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [N_CH-1:0]        sample_valid,
  input  logic [N_CH-1:0]        present,
  input  logic [N_CH*DIST_W-1:0] distance,
  output logic [N_CH*3-1:0]      zone,
  output logic [N_CH*DIST_W-1:0] dist_q,
  output logic [N_CH-1:0]        contact,
  output logic [NCH_W-1:0]       nearest_ch,
  output zone_t                  nearest_zone,
  output logic                   chime
);

  // Elaboration-time guard against configurations the datapath cannot represent.
  if (CONFIRM < 1 || CLK_PER_TICK < 1) begin : g_bad_cfg
    $error("proximity_monitor: CONFIRM and CLK_PER_TICK must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    prox_channel #(
      .DIST_W (DIST_W),
      .CONFIRM(CONFIRM),
      .Z1_FT  (Z1_FT),
      .Z2_FT  (Z2_FT),
      .Z3_FT  (Z3_FT),
      .Z4_FT  (Z4_FT)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .enable      (enable),
      .clear       (clear),
      .sample_valid(sample_valid[i]),
      .present     (present[i]),
      .distance    (distance[i*DIST_W +: DIST_W]),
      .zone        (zone[i*3 +: 3]),
      .dist_q      (dist_q[i*DIST_W +: DIST_W]),
      .contact     (contact[i])
    );
  end

  logic [NCH_W-1:0] near_ch_nx;
  zone_t            near_zone_nx;

  // Highest zone wins; strict compare keeps the lowest index on ties and ch0 when all OFF.
  always_comb begin
    near_ch_nx   = '0;
    near_zone_nx = ZONE_OFF;
    for (int i = 0; i < N_CH; i++) begin
      if (zone[i*3 +: 3] > near_zone_nx) begin
        near_zone_nx = zone[i*3 +: 3];
        near_ch_nx   = NCH_W'(i);
      end
    end
  end

  // Register the reduction so downstream logic sees a glitch-free result one cycle after zone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      nearest_ch   <= '0;
      nearest_zone <= ZONE_OFF;
    end else begin
      nearest_ch   <= near_ch_nx;
      nearest_zone <= near_zone_nx;
    end
  end

`ifdef PROX_CHIME_EN
  localparam int PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [CHIME_CNT_W-1:0] PHASE_1 = CHIME_CNT_W'(1);

  logic [PRE_W-1:0]       pre_cnt;
  logic [CHIME_CNT_W-1:0] phase;
  logic [CHIME_CNT_W-1:0] period;

  assign period = chime_period(nearest_zone);

  // Prescaler and tick phase; restarted on the same edge nearest_zone takes a new value
  // so the first cycle of the new zone already shows tick 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
      phase   <= '0;
    end else if (near_zone_nx != nearest_zone) begin
      pre_cnt <= '0;
      phase   <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      phase   <= (phase >= period - PHASE_1) ? '0 : phase + PHASE_1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Chime level derived purely from registers: silent, continuous, or first half of period.
  always_comb begin
    chime = 1'b0;
    case (nearest_zone)
      ZONE_OFF:               chime = 1'b0;
      ZONE_CRIT, ZONE_CONTACT: chime = 1'b1;
      default:                chime = (phase < (period >> 1));
    endcase
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_proximity_monitor.sv
// tb_proximity_monitor: directed stimulus with a cycle-tagged scoreboard.
// Stimulus pushes expected output values tagged with the cycle they must appear in;
// an independent monitor pops and compares them on the falling edge.
module tb_proximity_monitor;
  import prox_pkg::*;

  localparam int N_CH   = 2;
  localparam int DIST_W = 5;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enable;
  logic        clear;
  logic [1:0]  sample_valid;
  logic [1:0]  present;
  logic [9:0]  distance;
  logic [5:0]  zone;
  logic [9:0]  dist_q;
  logic [1:0]  contact;
  logic [0:0]  nearest_ch;
  zone_t       nearest_zone;
  logic        chime;

  always #5 CLK = ~CLK;

  proximity_monitor #(
    .N_CH        (N_CH),
    .DIST_W      (DIST_W),
    .CONFIRM     (2),
    .Z1_FT       (20),
    .Z2_FT       (10),
    .Z3_FT       (5),
    .Z4_FT       (1),
    .CLK_PER_TICK(4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .clear       (clear),
    .sample_valid(sample_valid),
    .present     (present),
    .distance    (distance),
    .zone        (zone),
    .dist_q      (dist_q),
    .contact     (contact),
    .nearest_ch  (nearest_ch),
    .nearest_zone(nearest_zone),
    .chime       (chime)
  );

  typedef enum {K_ZONE, K_DIST, K_CONTACT, K_NCH, K_NZONE, K_CHIME} kind_t;
  typedef struct {
    int    at;
    kind_t kind;
    int    ch;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record one comparison result and report it on failure.
  task automatic check(input logic ok, input string msg);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s", msg);
    end
  endtask

  // Queue an expectation dly edges from now, kept sorted by due cycle.
  task automatic push_exp(input int dly, input kind_t k, input int ch, input int v);
    exp_t e;
    int   pos;
    e   = '{at: cyc + dly, kind: k, ch: ch, val: v};
    pos = sb.size();
    while (pos > 0 && sb[pos-1].at > e.at) pos--;
    sb.insert(pos, e);
  endtask

  function automatic int actual(input kind_t k, input int ch);
    case (k)
      K_ZONE:    return int'(zone[ch*3 +: 3]);
      K_DIST:    return int'(dist_q[ch*DIST_W +: DIST_W]);
      K_CONTACT: return int'(contact[ch]);
      K_NCH:     return int'(nearest_ch);
      K_NZONE:   return int'(nearest_zone);
      default:   return int'(chime);
    endcase
  endfunction

  // Monitor: compare every expectation that falls due at this falling edge.
  always @(negedge CLK) begin : mon
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      a = actual(e.kind, e.ch);
      check(a == e.val, $sformatf("%s ch%0d cyc %0d: got %0d, expected %0d",
                                  e.kind.name(), e.ch, cyc, a, e.val));
    end
  end

  // One clock of stimulus, applied at a falling edge; strobes drop afterwards.
  task automatic drive(input logic [1:0] v, input logic [1:0] p,
                       input logic [4:0] d0, input logic [4:0] d1, input logic clr);
    sample_valid = v;
    present      = p;
    distance     = {d1, d0};
    clear        = clr;
    @(negedge CLK);
    sample_valid = '0;
    clear        = 1'b0;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic s0(input int d);
    drive(2'b01, 2'b01, 5'(d), 5'd0, 1'b0);
  endtask

  task automatic s1(input int d);
    drive(2'b10, 2'b10, 5'd0, 5'(d), 1'b0);
  endtask

  task automatic exp_near(input int dly, input int ch, input int z);
    push_exp(dly, K_NCH, 0, ch);
    push_exp(dly, K_NZONE, 0, z);
  endtask

  initial begin : stim
    int guard;
    RST = 1'b1; enable = 1'b0; clear = 1'b0;
    sample_valid = '0; present = '0; distance = '0;
    repeat (2) @(negedge CLK);

    check(zone == 6'd0, "reset: zone not 0");
    check(dist_q == 10'd0, "reset: dist_q not 0");
    check(contact == 2'b00, "reset: contact not 0");
    check(nearest_zone == ZONE_OFF, "reset: nearest_zone not 0");
    check(chime == 1'b0, "reset: chime not 0");

    // Reset state.
    for (int c = 0; c < N_CH; c++) begin
      push_exp(1, K_ZONE, c, 0);
      push_exp(1, K_DIST, c, 0);
      push_exp(1, K_CONTACT, c, 0);
    end
    exp_near(1, 0, 0);
    push_exp(1, K_CHIME, 0, 0);
    idle();
    RST = 1'b0; enable = 1'b1;

    // ch0 d=15 twice -> FAR on the second sample, nearest one cycle later.
    push_exp(1, K_ZONE, 0, 0);
    s0(15);
    push_exp(1, K_ZONE, 0, 1);
    push_exp(1, K_DIST, 0, 15);
    push_exp(1, K_NZONE, 0, 0);
    exp_near(2, 0, 1);
    s0(15);
    idle();

    // ch1 d=20, 3, 3 -> stays OFF, then jumps straight to NEAR.
    push_exp(1, K_ZONE, 1, 0);
    s1(20);
    push_exp(1, K_ZONE, 1, 0);
    s1(3);
    push_exp(1, K_ZONE, 1, 3);
    push_exp(1, K_DIST, 1, 3);
    exp_near(2, 1, 3);
    s1(3);
    idle();

    // ch0 to MID, then a broken streak 4/9/4 leaves it at MID.
    s0(8);
    push_exp(1, K_ZONE, 0, 2);
    push_exp(1, K_DIST, 0, 8);
    s0(8);
    push_exp(1, K_ZONE, 0, 2);
    s0(4);
    push_exp(1, K_ZONE, 0, 2);
    s0(9);
    push_exp(1, K_ZONE, 0, 2);
    push_exp(1, K_DIST, 0, 8);
    s0(4);
    idle();

    // Tie at MID resolves to ch0; ch1 raised to NEAR (streak held across an idle gap).
    s1(7);
    push_exp(1, K_ZONE, 1, 2);
    exp_near(2, 0, 2);
    s1(7);
    idle();
    push_exp(1, K_ZONE, 1, 2);
    s1(5);
    idle();
    push_exp(1, K_ZONE, 1, 3);
    exp_near(2, 1, 3);
    s1(5);
    idle();

    // Contact on ch0: immediate latch, later samples ignored, clear releases.
    push_exp(1, K_ZONE, 0, 5);
    push_exp(1, K_CONTACT, 0, 1);
    push_exp(1, K_DIST, 0, 0);
    push_exp(1, K_CONTACT, 1, 0);
    exp_near(2, 0, 5);
    s0(0);
    push_exp(1, K_ZONE, 0, 5);
    s0(15);
    push_exp(1, K_ZONE, 0, 5);
    push_exp(1, K_CONTACT, 0, 1);
    s0(15);
    push_exp(1, K_ZONE, 0, 0);
    push_exp(1, K_CONTACT, 0, 0);
    exp_near(2, 1, 3);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 1'b1);
    idle();

    // Re-latch, then clear together with a contact sample keeps the latch.
    push_exp(1, K_ZONE, 0, 5);
    s0(0);
    push_exp(1, K_ZONE, 0, 5);
    push_exp(1, K_CONTACT, 0, 1);
    drive(2'b01, 2'b01, 5'd0, 5'd0, 1'b1);
    idle();

    // ch1 boundaries: d=1 -> CRIT, d=21 -> OFF, present=0 -> OFF.
    s1(1);
    push_exp(1, K_ZONE, 1, 4);
    exp_near(2, 0, 5);
    s1(1);
    push_exp(1, K_ZONE, 1, 4);
    s1(21);
    push_exp(1, K_ZONE, 1, 0);
    s1(21);
    s1(3);
    push_exp(1, K_ZONE, 1, 3);
    s1(3);
    drive(2'b10, 2'b00, 5'd0, 5'd3, 1'b0);
    push_exp(1, K_ZONE, 1, 0);
    drive(2'b10, 2'b00, 5'd0, 5'd3, 1'b0);
    s1(4);
    push_exp(1, K_ZONE, 1, 3);
    s1(4);

    // enable=0 forces tracking channels OFF and ignores samples; the latch survives.
    enable = 1'b0;
    push_exp(1, K_ZONE, 1, 0);
    push_exp(1, K_ZONE, 0, 5);
    push_exp(1, K_CONTACT, 0, 1);
    s1(4);
    push_exp(1, K_ZONE, 1, 0);
    s1(4);
    enable = 1'b1;
    push_exp(1, K_ZONE, 1, 0);
    s1(4);

    // Release ch0: everything OFF -> nearest falls back to ch0 / OFF.
    push_exp(1, K_ZONE, 0, 0);
    push_exp(1, K_CONTACT, 0, 0);
    exp_near(2, 0, 0);
    drive(2'b00, 2'b00, 5'd0, 5'd0, 1'b1);
    idle();

    // ch1 already holds a one-sample NEAR streak, so this sample confirms NEAR.
    push_exp(1, K_ZONE, 1, 3);
    exp_near(2, 1, 3);
`ifdef PROX_CHIME_EN
    // 4 clocks/tick, period 4 ticks: 8 cycles high, 8 low, then high again.
    for (int d = 2; d <= 9; d++)   push_exp(d, K_CHIME, 0, 1);
    for (int d = 10; d <= 17; d++) push_exp(d, K_CHIME, 0, 0);
    push_exp(18, K_CHIME, 0, 1);
`else
    for (int d = 2; d <= 6; d++) push_exp(d, K_CHIME, 0, 0);
`endif
    s1(4);
    repeat (18) idle();

    // CRIT -> continuous chime (silent when the feature is absent).
    s1(1);
    exp_near(2, 1, 4);
`ifdef PROX_CHIME_EN
    for (int d = 2; d <= 6; d++) push_exp(d, K_CHIME, 0, 1);
`else
    for (int d = 2; d <= 6; d++) push_exp(d, K_CHIME, 0, 0);
`endif
    s1(1);
    repeat (5) idle();

    // enable=0 silences the chime within two cycles.
    enable = 1'b0;
    push_exp(1, K_ZONE, 1, 0);
    push_exp(2, K_CHIME, 0, 0);
    push_exp(2, K_NZONE, 0, 0);
    idle();
    idle();
    idle();

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s ch%0d never checked: expected %0d by cyc %0d",
               e.kind.name(), e.ch, e.val, e.at);
    end

    check(zone == 6'd0, "end: zone not all OFF");
    check(contact == 2'b00, "end: contact not clear");
    check(nearest_zone == ZONE_OFF, "end: nearest_zone not 0");
    check(chime == 1'b0, "end: chime not silent");
    check(sb.size() == 0, "end: scoreboard not empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
